// File: rtl/alarm_ctrl.sv
// Alarm stage for the HH:MM:SS clock: programmable alarm time, ring/snooze/stop/timeout FSM.
// Optional hourly chime is compiled in when ALARM_CHIME_EN is defined.
module alarm_ctrl #(
    parameter int DEF_H      = 6,
    parameter int DEF_M      = 0,
    parameter int SNOOZE_MIN = 9,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       SEC,
    input  logic [4:0] HOURS,
    input  logic [5:0] MINUTES,
    input  logic [5:0] SECONDS,
    input  logic [4:0] SET_H,
    input  logic [5:0] SET_M,
    input  logic       SET_LOAD,
    input  logic       ARM,
    input  logic       SNOOZE,
    input  logic       STOP,
    output logic [4:0] ALARM_H,
    output logic [5:0] ALARM_M,
    output logic       LOAD_ERR,
    output logic       ARMED,
    output logic       RINGING,
    output logic       BLINK,
    output logic       SNOOZING,
    output logic [1:0] SNZ_CNT,
    output logic       CHIME
);

    localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);
    localparam logic [7:0]  RING_LAST = 8'(RING_SEC - 1);

    typedef enum logic [1:0] {
        S_DISARMED,
        S_ARMED,
        S_RINGING,
        S_SNOOZING
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  ring_q, ring_d;
    logic [11:0] snz_left_q, snz_left_d;
    logic [1:0]  snz_cnt_d;
    logic        blink_d;
    logic        hit_q, hit_prev, trigger;
    logic        load_ok;

    // Edge-detect the match so one matching second produces a single trigger.
    assign trigger = hit_q & ~hit_prev;
    assign load_ok = (SET_H <= 5'd23) && (SET_M <= 6'd59);

    always_comb begin
        state_d    = state_q;
        ring_d     = ring_q;
        snz_left_d = snz_left_q;
        snz_cnt_d  = SNZ_CNT;
        blink_d    = BLINK;
        if (!ARM) begin
            state_d    = S_DISARMED;
            ring_d     = 8'd0;
            snz_left_d = 12'd0;
            snz_cnt_d  = 2'd0;
            blink_d    = 1'b0;
        end else begin
            case (state_q)
                S_DISARMED: state_d = S_ARMED;
                S_ARMED: begin
                    if (trigger) begin
                        state_d = S_RINGING;
                        ring_d  = 8'd0;
                        blink_d = 1'b1;
                    end
                end
                S_RINGING: begin
                    // A SNOOZE beyond the allowance falls through to normal second counting.
                    if (STOP) begin
                        state_d   = S_ARMED;
                        snz_cnt_d = 2'd0;
                        blink_d   = 1'b0;
                    end else if (SNOOZE && (int'(SNZ_CNT) < MAX_SNOOZE)) begin
                        state_d    = S_SNOOZING;
                        snz_cnt_d  = SNZ_CNT + 2'd1;
                        snz_left_d = SNZ_LOAD;
                        blink_d    = 1'b0;
                    end else if (SEC) begin
                        if (ring_q == RING_LAST) begin
                            state_d   = S_ARMED;
                            ring_d    = 8'd0;
                            snz_cnt_d = 2'd0;
                            blink_d   = 1'b0;
                        end else begin
                            ring_d  = ring_q + 8'd1;
                            blink_d = ~BLINK;
                        end
                    end
                end
                S_SNOOZING: begin
                    if (STOP) begin
                        state_d    = S_ARMED;
                        snz_cnt_d  = 2'd0;
                        snz_left_d = 12'd0;
                    end else if (SEC) begin
                        if (snz_left_q <= 12'd1) begin
                            state_d    = S_RINGING;
                            snz_left_d = 12'd0;
                            ring_d     = 8'd0;
                            blink_d    = 1'b1;
                        end else begin
                            snz_left_d = snz_left_q - 12'd1;
                        end
                    end
                end
                default: state_d = S_DISARMED;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_DISARMED;
            ring_q     <= 8'd0;
            snz_left_q <= 12'd0;
            SNZ_CNT    <= 2'd0;
            BLINK      <= 1'b0;
            ARMED      <= 1'b0;
            RINGING    <= 1'b0;
            SNOOZING   <= 1'b0;
            hit_q      <= 1'b0;
            hit_prev   <= 1'b0;
            ALARM_H    <= 5'(DEF_H);
            ALARM_M    <= 6'(DEF_M);
            LOAD_ERR   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_q     <= ring_d;
            snz_left_q <= snz_left_d;
            SNZ_CNT    <= snz_cnt_d;
            BLINK      <= blink_d;
            ARMED      <= (state_d != S_DISARMED);
            RINGING    <= (state_d == S_RINGING);
            SNOOZING   <= (state_d == S_SNOOZING);
            hit_q      <= ARM && (HOURS == ALARM_H) && (MINUTES == ALARM_M) && (SECONDS == 6'd0);
            hit_prev   <= hit_q;
            LOAD_ERR   <= SET_LOAD && !load_ok;
            if (SET_LOAD && load_ok) begin
                ALARM_H <= SET_H;
                ALARM_M <= SET_M;
            end
        end
    end

`ifdef ALARM_CHIME_EN
    // Chime is resampled every second, so it stays up for exactly the top-of-hour second.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            CHIME <= 1'b0;
        end else if (!ARM) begin
            CHIME <= 1'b0;
        end else if (SEC) begin
            CHIME <= (MINUTES == 6'd0) && (SECONDS == 6'd0);
        end
    end
`else
    assign CHIME = 1'b0;
`endif

endmodule
